uart_interface: RTL and testbench
=================================

UART_INTERFACE -- requirements
Module: uart_interface

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
REQ-003 The module SHALL have a single port, uart, of interface type uart_if; all signals below are members of it, directions given relative to the block.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 transmit  input  1  start-transmission request, sampled on rising clk.
REQ-007 TxData  input  8  byte to send, captured when a request is accepted.
REQ-008 busy  output  1  high while a transmit frame is in progress.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 RxData  output  8  last correctly received byte.
REQ-011 valid_rx  output  1  one-cycle pulse when RxData is updated.

Function
REQ-012 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly CLKS_PER_BIT clocks.
REQ-013 The receiver input SHALL be internally looped back from tx through a 2-flop synchronizer; no external serial input exists.
REQ-014 TX states SHALL be IDLE, START, DATA, STOP; IDLE->START on transmit=1 with busy=0, START->DATA after one bit time, DATA->STOP after 8 bits, STOP->IDLE after one bit time.
REQ-015 On acceptance, TxData SHALL be latched, and busy and tx=0 SHALL both be asserted on the following rising edge.
REQ-016 busy SHALL deassert on the clock edge where the stop bit's full bit time ends; a new request is acceptable on that same or any later cycle.
REQ-017 transmit asserted while busy=1 SHALL be ignored; changes to TxData during a frame SHALL not affect the frame in flight.
REQ-018 transmit held high across frames SHALL start a new frame each time busy returns to 0 (level-sensitive).
REQ-019 RX states SHALL be IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge (1->0).
REQ-020 In START the receiver SHALL resample at CLKS_PER_BIT/2; if the line is 1, return to IDLE (glitch reject), otherwise proceed.
REQ-021 Data bits SHALL be sampled at mid-bit, every CLKS_PER_BIT clocks thereafter, shifted in LSB first.
REQ-022 At mid-stop-bit: if the line is 1, RxData SHALL be updated and valid_rx pulsed high for exactly one clock; if 0 (framing error), the byte SHALL be discarded, RxData left unchanged, no pulse; RX then returns to IDLE.
REQ-023 valid_rx for a frame SHALL occur before busy for that frame deasserts (mid-stop vs end-of-stop).
REQ-024 RxData SHALL hold its value between valid_rx pulses.
REQ-025 TX and RX SHALL operate independently; RX hunts for a new start bit immediately after the stop sample.

Reset
REQ-026 While reset=1: tx=1, busy=0, valid_rx=0, RxData=8'h00, both FSMs in IDLE, counters and shift registers cleared, synchronizer flops set to 1.
REQ-027 Reset asserted mid-frame SHALL abort both TX and RX immediately; no valid_rx pulse for the aborted frame.
REQ-028 After reset deasserts, the first transmit request SHALL be accepted on the first rising clk edge it is seen.

Verification
REQ-029 Reset 200 ns, then send 8'h41 ('A') -> busy high for 10*434 clocks; one valid_rx pulse with RxData=8'h41.
REQ-030 Back-to-back "AISHWARYA" (each waiting for busy=0) -> nine valid_rx pulses with RxData matching each byte in order, no extra pulses.
REQ-031 Pulse transmit with 8'h55 while busy for 8'hA5 -> only 8'hA5 received; 8'h55 never transmitted.
REQ-032 Check tx waveform for 8'h01 -> low 434 clocks, high 434, low 7*434, high 434 (stop).
REQ-033 Assert reset halfway through a frame -> tx=1, busy=0 immediately; no valid_rx; next byte 8'h5A received correctly.
REQ-034 Send 8'h00 and 8'hFF -> RxData=8'h00 then 8'hFF, each with a single valid_rx pulse.

Source files
------------

// File: rtl/uart_interface_if.sv
// -----------------------------------------------------------------------------
// uart_if -- signal bundle for the loop-back UART block.
//
// Members (directions as seen by the block, see modport dut):
//   clk       in   system clock, rising-edge logic
//   reset     in   asynchronous, active-high reset
//   transmit  in   start-transmission request (level, sampled on clk)
//   TxData    in   byte to send, captured when a request is accepted
//   busy      out  high while a transmit frame is in progress
//   tx        out  serial line, idles high
//   RxData    out  last correctly received byte
//   valid_rx  out  one-cycle pulse when RxData is updated
// -----------------------------------------------------------------------------
interface uart_if;
  logic       clk;
  logic       reset;
  logic       transmit;
  logic [7:0] TxData;
  logic       busy;
  logic       tx;
  logic [7:0] RxData;
  logic       valid_rx;

  modport dut (
    input  clk,
    input  reset,
    input  transmit,
    input  TxData,
    output busy,
    output tx,
    output RxData,
    output valid_rx
  );
endinterface

// File: rtl/uart_interface.sv
// -----------------------------------------------------------------------------
// uart_interface -- 8N1 UART transmitter with the receiver looped back from
// its own tx line through a 2-flop synchronizer.
//
// Port: uart (uart_if.dut)
//   clk, reset, transmit, TxData  -> inputs
//   busy, tx, RxData, valid_rx    -> outputs
//
// Request handshake: transmit is a level request. It is accepted on any
// rising clk edge where the TX FSM is IDLE (busy=0); on that edge TxData is
// latched, and busy=1 / tx=0 appear right after it. While busy=1 the request
// is ignored. Holding transmit high restarts a frame every time busy falls.
// valid_rx is a single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module uart_interface #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  uart_if.dut uart
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_idx, tx_idx_n;
  logic [7:0]      tx_shreg, tx_shreg_n;
  logic            tx_line, tx_line_n;
  logic            busy_r, busy_n;

  always_ff @(posedge uart.clk or posedge uart.reset) begin
    if (uart.reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_line  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shreg <= tx_shreg_n;
      tx_line  <= tx_line_n;
      busy_r   <= busy_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shreg_n = tx_shreg;
    tx_line_n  = tx_line;
    busy_n     = busy_r;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (uart.transmit) begin
          tx_state_n = START;
          tx_shreg_n = uart.TxData;
          tx_idx_n   = '0;
          tx_line_n  = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = DATA;
          tx_cnt_n   = '0;
          tx_line_n  = tx_shreg[0];
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_state_n = STOP;
            tx_line_n  = 1'b1;
          end else begin
            // Shift so the next bit to send always sits at bit 1 before the
            // shift and bit 0 after it.
            tx_idx_n   = tx_idx + 3'd1;
            tx_shreg_n = {1'b0, tx_shreg[7:1]};
            tx_line_n  = tx_shreg[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = IDLE;
          tx_cnt_n   = '0;
          busy_n     = 1'b0;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- receiver (looped back from tx) ----------------
  logic            rx_sync1, rx_sync2, rx_prev;
  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_idx, rx_idx_n;
  logic [7:0]      rx_shreg, rx_shreg_n;
  logic [7:0]      rx_data, rx_data_n;
  logic            valid_r, valid_n;

  always_ff @(posedge uart.clk or posedge uart.reset) begin
    if (uart.reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
      rx_data  <= '0;
      valid_r  <= 1'b0;
    end else begin
      rx_sync1 <= tx_line;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shreg <= rx_shreg_n;
      rx_data  <= rx_data_n;
      valid_r  <= valid_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shreg_n = rx_shreg;
    rx_data_n  = rx_data;
    valid_n    = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync2) begin
          rx_state_n = START;
          rx_idx_n   = '0;
        end
      end
      START: begin
        // Half a bit in: a high line means the falling edge was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shreg_n = {rx_sync2, rx_shreg[7:1]};
          if (rx_idx == 3'd7) rx_state_n = STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end
      end
      STOP: begin
        // Mid-stop sample: a low line is a framing error and drops the byte.
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = IDLE;
          if (rx_sync2) begin
            rx_data_n = rx_shreg;
            valid_n   = 1'b1;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  assign uart.tx       = tx_line;
  assign uart.busy     = busy_r;
  assign uart.RxData   = rx_data;
  assign uart.valid_rx = valid_r;

endmodule

// File: tb/tb_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_uart_interface -- directed bench for uart_interface.
// Runs the block at CLK_FREQ=1_000_000, BAUD=48_000, so one bit lasts
// 1e6/48e3 = 20.83 -> 20 clocks (exercises the integer truncation).
// -----------------------------------------------------------------------------
module tb_uart_interface;

  localparam int CPB = 20;

  uart_if bus ();

  uart_interface #(
    .CLK_FREQ(1_000_000),
    .BAUD    (48_000)
  ) dut (
    .uart(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pulse_total = 0;
  int         pulse_expected = 0;
  int         valid_run = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
    int         exp_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receive monitor: logs each valid_rx pulse and checks it lasts one cycle.
  always @(negedge bus.clk) begin
    if (bus.valid_rx === 1'b1) begin
      valid_run++;
      if (valid_run == 1) begin
        got_q.push_back(bus.RxData);
        pulse_total++;
      end
    end else if (valid_run != 0) begin
      check("valid_rx_width", valid_run, 1);
      valid_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic level, input int max, output int n);
    n = 0;
    while (bus.busy !== level && n < max) begin
      @(negedge bus.clk);
      n++;
    end
    if (bus.busy !== level) begin
      checks++;
      errors++;
      $display("FAIL busy_wait_timeout: busy=%b after %0d cycles, wanted %b", bus.busy, n, level);
    end
  endtask

  // Sends one byte and checks busy length, tx waveform and the looped-back
  // byte. Optionally pulses transmit with another byte mid-frame.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] exp_rx, input int exp_busy,
                           input bit inject, input logic [7:0] inj_d);
    logic [9:0] frame;
    int         busy_cycles;
    int         wave_err;
    frame = {1'b1, d, 1'b0};
    busy_cycles = 0;
    wave_err = 0;
    exp_q.push_back(exp_rx);
    pulse_expected++;
    @(negedge bus.clk);
    bus.transmit = 1'b1;
    bus.TxData   = d;
    @(negedge bus.clk);
    bus.transmit = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_tx_low", bus.tx, 0);
    for (int k = 0; k < 12 * CPB; k++) begin
      if (bus.busy !== 1'b1) break;
      busy_cycles++;
      if (k < 10 * CPB && bus.tx !== frame[k / CPB]) wave_err++;
      if (inject && k == 3 * CPB) begin
        bus.transmit = 1'b1;
        bus.TxData   = inj_d;
      end
      if (inject && k == 3 * CPB + 1) bus.transmit = 1'b0;
      @(negedge bus.clk);
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: busy still high for byte %0h", d);
    end
    check("busy_len", busy_cycles, exp_busy);
    check("tx_wave_errs", wave_err, 0);
    check("rx_before_busy_fall", got_q.size(), 1);
    if (got_q.size() > 0) check("rx_data", got_q.pop_front(), exp_q.pop_front());
    else void'(exp_q.pop_front());
    check("rx_data_hold", bus.RxData, exp_rx);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    vecs[0]  = '{8'h41, 8'h41, 10 * CPB};
    vecs[1]  = '{8'h41, 8'h41, 10 * CPB};  // A
    vecs[2]  = '{8'h49, 8'h49, 10 * CPB};  // I
    vecs[3]  = '{8'h53, 8'h53, 10 * CPB};  // S
    vecs[4]  = '{8'h48, 8'h48, 10 * CPB};  // H
    vecs[5]  = '{8'h57, 8'h57, 10 * CPB};  // W
    vecs[6]  = '{8'h41, 8'h41, 10 * CPB};  // A
    vecs[7]  = '{8'h52, 8'h52, 10 * CPB};  // R
    vecs[8]  = '{8'h59, 8'h59, 10 * CPB};  // Y
    vecs[9]  = '{8'h41, 8'h41, 10 * CPB};  // A
    vecs[10] = '{8'h01, 8'h01, 10 * CPB};
    vecs[11] = '{8'h00, 8'h00, 10 * CPB};
    vecs[12] = '{8'hFF, 8'hFF, 10 * CPB};

    bus.reset    = 1'b1;
    bus.transmit = 1'b0;
    bus.TxData   = 8'h00;
    #195;
    check("reset_tx", bus.tx, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_valid", bus.valid_rx, 0);
    check("reset_rxdata", bus.RxData, 8'h00);
    #5;
    bus.reset = 1'b0;

    // Table: 'A', then "AISHWARYA" back to back, then 01 / 00 / FF.
    for (int i = 0; i < 13; i++)
      send_byte(vecs[i].data, vecs[i].exp_rx, vecs[i].exp_busy, 1'b0, 8'h00);

    // Request for 55 while A5 is in flight must be dropped.
    send_byte(8'hA5, 8'hA5, 10 * CPB, 1'b1, 8'h55);
    repeat (3 * CPB) @(negedge bus.clk);
    check("ignored_no_busy", bus.busy, 0);
    check("ignored_no_rx", got_q.size(), 0);

    // transmit held high: second frame starts as soon as busy drops.
    @(negedge bus.clk);
    bus.transmit = 1'b1;
    bus.TxData   = 8'h3C;
    pulse_expected += 2;
    wait_busy(1'b1, 4, n);
    check("held_first_accept", n, 1);
    wait_busy(1'b0, 12 * CPB, n);
    check("held_busy_len1", n, 10 * CPB);
    wait_busy(1'b1, 4, n);
    check("held_restart", (n >= 1 && n <= 2), 1);
    bus.transmit = 1'b0;
    wait_busy(1'b0, 12 * CPB, n);
    check("held_busy_len2", (n >= 10 * CPB - 1 && n <= 10 * CPB), 1);
    check("held_rx_count", got_q.size(), 2);
    while (got_q.size() > 0) check("held_rx_data", got_q.pop_front(), 8'h3C);
    repeat (3 * CPB) @(negedge bus.clk);
    check("held_no_third", bus.busy, 0);

    // Reset halfway through a frame aborts TX and RX at once.
    @(negedge bus.clk);
    bus.transmit = 1'b1;
    bus.TxData   = 8'h77;
    @(negedge bus.clk);
    bus.transmit = 1'b0;
    repeat (5 * CPB) @(negedge bus.clk);
    #2;
    bus.reset = 1'b1;
    #1;
    check("abort_tx", bus.tx, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.valid_rx, 0);
    check("abort_rxdata", bus.RxData, 8'h00);
    repeat (3) @(negedge bus.clk);
    bus.reset = 1'b0;
    repeat (12 * CPB) @(negedge bus.clk);
    check("abort_no_rx", got_q.size(), 0);
    check("abort_idle_tx", bus.tx, 1);
    send_byte(8'h5A, 8'h5A, 10 * CPB, 1'b0, 8'h00);

    repeat (2 * CPB) @(negedge bus.clk);
    check("final_rxdata_hold", bus.RxData, 8'h5A);
    check("pulse_total", pulse_total, pulse_expected);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
